dom_gf4_mul_sched: RTL



---
 rtl/dom_gf4_mul_sched_if.sv | 42 ++++
 rtl/dom_gf4_mul_sched.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dom_gf4_mul_sched_if.sv
// Bus bundle between the GF(4) multiplier scheduler, its requesters, the
// randomness source and the shared masked multiplier.
//   Request side : ReqValidxSI / ReqReadyxSO handshake, ReqXxDI / ReqYxDI
//                  operands (requester r in slice r), RespValidxSO one-hot
//                  result strobe, RespQxDO registered result.
//   Randomness   : RandValidxSI / RandReadyxSO handshake, RandxDI word.
//   Multiplier   : MulXxDO / MulYxDO / MulZxDO to it, MulQxDI back from it.
// The scheduler connects through the slave modport; its environment through
// the master modport.
interface dom_gf4_mul_sched_if #(
    parameter int SHARES = 4,
    parameter int NREQ   = 2
);
    localparam int W  = 4 * SHARES;
    localparam int ZW = 2 * SHARES * (SHARES - 1);

    logic [NREQ-1:0]   ReqValidxSI;
    logic [NREQ-1:0]   ReqReadyxSO;
    logic [NREQ*W-1:0] ReqXxDI;
    logic [NREQ*W-1:0] ReqYxDI;
    logic              RandValidxSI;
    logic [ZW-1:0]     RandxDI;
    logic              RandReadyxSO;
    logic [W-1:0]      MulXxDO;
    logic [W-1:0]      MulYxDO;
    logic [ZW-1:0]     MulZxDO;
    logic [W-1:0]      MulQxDI;
    logic [NREQ-1:0]   RespValidxSO;
    logic [W-1:0]      RespQxDO;

    modport slave (
        input  ReqValidxSI, ReqXxDI, ReqYxDI, RandValidxSI, RandxDI, MulQxDI,
        output ReqReadyxSO, RandReadyxSO, MulXxDO, MulYxDO, MulZxDO,
               RespValidxSO, RespQxDO
    );

    modport master (
        output ReqValidxSI, ReqXxDI, ReqYxDI, RandValidxSI, RandxDI, MulQxDI,
        input  ReqReadyxSO, RandReadyxSO, MulXxDO, MulYxDO, MulZxDO,
               RespValidxSO, RespQxDO
    );
endinterface

// File: rtl/dom_gf4_mul_sched.sv
// Round-robin scheduler that time-multiplexes one shared masked GF(4)
// multiplier (latency LAT) among NREQ requesters. Each issued operation
// consumes exactly one fresh randomness word; a LAT-deep {valid, id} shift
// register follows the operation through the multiplier so the result can be
// registered and steered back to the requester that issued it.
// Ports:
//   ClkxCI       clock
//   RstxRI       synchronous active-high reset
//   EnablexSI    1 = issue allowed, 0 = stop issuing and drain
//   Bus          request / randomness / multiplier bundle (slave side)
//   IdlexSO      registered: IDLE and nothing in flight
//   IssueCntxDO  saturating count of issued operations
module dom_gf4_mul_sched #(
    parameter int SHARES = 4,
    parameter int NREQ   = 2,
    parameter int LAT    = 1
) (
    input  logic                  ClkxCI,
    input  logic                  RstxRI,
    input  logic                  EnablexSI,
    dom_gf4_mul_sched_if.slave    Bus,
    output logic                  IdlexSO,
    output logic [15:0]           IssueCntxDO
);
    localparam int W   = 4 * SHARES;
    localparam int ZW  = 2 * SHARES * (SHARES - 1);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   StatexDP, StatexDN;
    logic [IDW-1:0]           PtrxDP, PtrxDN;
    logic [IDW-1:0]           GrantIdxxD;
    logic [IDW-1:0]           CandxD;
    logic                     FoundxS;
    logic                     IssuexS;
    logic [W-1:0]             SelXxD, SelYxD;
    logic [LAT-1:0]           InflVldxDP, InflVldxDN;
    logic [LAT-1:0][IDW-1:0]  InflIdxDP, InflIdxDN;
    logic [NREQ-1:0]          RespValidxDP;
    logic [W-1:0]             RespQxDP;
    logic                     IdlexDP, IdlexDN;
    logic [15:0]              IssueCntxDP, IssueCntxDN;

    // Round-robin arbiter: first valid requester at or after the pointer.
    always_comb begin
        GrantIdxxD = '0;
        FoundxS    = 1'b0;
        CandxD     = '0;
        for (int k = 0; k < NREQ; k++) begin
            CandxD     = IDW'((int'(PtrxDP) + k) % NREQ);
            GrantIdxxD = (!FoundxS && Bus.ReqValidxSI[CandxD]) ? CandxD : GrantIdxxD;
            FoundxS    = FoundxS | Bus.ReqValidxSI[CandxD];
        end
    end

    // Issue qualification and operand steering; operands are zeroed when
    // nothing issues so no stale shares reach the multiplier.
    always_comb begin
        IssuexS = (StatexDP == RUN) && EnablexSI && Bus.RandValidxSI
                  && (|Bus.ReqValidxSI);
        SelXxD  = '0;
        SelYxD  = '0;
        for (int r = 0; r < NREQ; r++) begin
            SelXxD = (GrantIdxxD == IDW'(r)) ? Bus.ReqXxDI[r*W +: W] : SelXxD;
            SelYxD = (GrantIdxxD == IDW'(r)) ? Bus.ReqYxDI[r*W +: W] : SelYxD;
        end
        Bus.MulXxDO      = IssuexS ? SelXxD : '0;
        Bus.MulYxDO      = IssuexS ? SelYxD : '0;
        Bus.MulZxDO      = IssuexS ? Bus.RandxDI : {ZW{1'b0}};
        Bus.ReqReadyxSO  = IssuexS ? (NREQ'(1) << GrantIdxxD) : '0;
        Bus.RandReadyxSO = IssuexS;
    end

    // Next-state logic; returning to RUN takes priority over finishing a drain.
    always_comb begin
        StatexDN = StatexDP;
        case (StatexDP)
            IDLE:    StatexDN = EnablexSI ? RUN : IDLE;
            RUN:     StatexDN = EnablexSI ? RUN : DRAIN;
            DRAIN: begin
                if (EnablexSI) begin
                    StatexDN = RUN;
                end else if (InflVldxDP == '0) begin
                    StatexDN = IDLE;
                end else begin
                    StatexDN = DRAIN;
                end
            end
            default: StatexDN = IDLE;
        endcase
    end

    // In-flight shift register, pointer, counter and idle-flag next values.
    always_comb begin
        InflVldxDN    = InflVldxDP;
        InflIdxDN     = InflIdxDP;
        InflVldxDN[0] = IssuexS;
        InflIdxDN[0]  = GrantIdxxD;
        for (int i = 1; i < LAT; i++) begin
            InflVldxDN[i] = InflVldxDP[i-1];
            InflIdxDN[i]  = InflIdxDP[i-1];
        end
        PtrxDN = IssuexS ? ((GrantIdxxD == IDW'(NREQ - 1)) ? '0 : GrantIdxxD + IDW'(1))
                         : PtrxDP;
        IssueCntxDN = (IssuexS && (IssueCntxDP != 16'hFFFF)) ? IssueCntxDP + 16'd1
                                                               : IssueCntxDP;
        IdlexDN = (StatexDN == IDLE) && (InflVldxDN == '0);
    end

    // State registers; the tail of the in-flight register marks the cycle in
    // which MulQxDI carries that operation's result.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            StatexDP     <= IDLE;
            PtrxDP       <= '0;
            InflVldxDP   <= '0;
            InflIdxDP    <= '0;
            RespValidxDP <= '0;
            RespQxDP     <= '0;
            IdlexDP      <= 1'b1;
            IssueCntxDP  <= 16'd0;
        end else begin
            StatexDP     <= StatexDN;
            PtrxDP       <= PtrxDN;
            InflVldxDP   <= InflVldxDN;
            InflIdxDP    <= InflIdxDN;
            RespValidxDP <= InflVldxDP[LAT-1] ? (NREQ'(1) << InflIdxDP[LAT-1]) : '0;
            RespQxDP     <= InflVldxDP[LAT-1] ? Bus.MulQxDI : RespQxDP;
            IdlexDP      <= IdlexDN;
            IssueCntxDP  <= IssueCntxDN;
        end
    end

    assign Bus.RespValidxSO = RespValidxDP;
    assign Bus.RespQxDO     = RespQxDP;
    assign IdlexSO          = IdlexDP;
    assign IssueCntxDO      = IssueCntxDP;
endmodule
